// File: rtl/fp_to_int_pkg.sv
// rtl/fp_to_int_pkg.sv - shared float classes, exception flags and integer limits for the converter.
// Build option FP2INT_ROUND_NEAREST_EN is consumed by fp_to_int.
package fp_to_int_pkg;

  typedef enum logic [1:0] {
    FPC_ZERO,
    FPC_NORMAL,
    FPC_INF,
    FPC_NAN
  } fp_class_t;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic inexact;
  } fp_flags_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_SHIFT,
    ST_ROUND,
    ST_DONE
  } cvt_state_t;

  function automatic int exp_offset(input int nx);
    return (1 << (nx - 1)) - 1;
  endfunction

  // Wide patterns; callers slice the low NI bits.
  function automatic logic [127:0] int_max(input int ni);
    return (128'd1 << (ni - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] int_min(input int ni);
    return 128'd1 << (ni - 1);
  endfunction

  function automatic fp_flags_t make_flags(input logic inv, input logic ovf, input logic inx);
    fp_flags_t f;
    f.invalid  = inv;
    f.overflow = ovf;
    f.inexact  = inx;
    return f;
  endfunction

endpackage

// File: rtl/fp_to_int_classify.sv
// rtl/fp_to_int_classify.sv - combinational IEEE754 classifier: class, sign and unbiased exponent.
module fp_to_int_classify
  import fp_to_int_pkg::*;
#(
  parameter int NX = 8,
  parameter int NM = 23
) (
  input  logic [NX+NM:0]     i_fp,
  output fp_class_t          o_class,
  output logic               o_sign,
  output logic signed [NX:0] o_exp
);

  localparam int            L_BIAS_I = exp_offset(NX);
  localparam logic [NX:0]   L_BIAS   = L_BIAS_I[NX:0];

  logic [NX-1:0] w_exp;
  logic [NM-1:0] w_mant;

  assign w_exp  = i_fp[NX+NM-1:NM];
  assign w_mant = i_fp[NM-1:0];
  assign o_sign = i_fp[NX+NM];
  assign o_exp  = $signed({1'b0, w_exp} - L_BIAS);

  always_comb begin
    o_class = FPC_NORMAL;
    if (&w_exp) begin
      o_class = (w_mant != '0) ? FPC_NAN : FPC_INF;
    end else if (w_exp == '0) begin
      o_class = FPC_ZERO;
    end
  end

endmodule

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - iterative IEEE754 to signed integer converter with valid/ready handshakes.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; default truncates toward zero.
module fp_to_int
  import fp_to_int_pkg::*;
#(
  parameter int NX = 8,
  parameter int NM = 23,
  parameter int NI = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [NX+NM:0]  i_in_fp,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [NI-1:0]   o_out_int,
  output logic [2:0]      o_out_flags
);

  localparam int W  = NI + NM + 1;
  localparam int CW = $clog2(NI + 1);

  localparam logic [127:0]  L_MAX_WIDE = int_max(NI);
  localparam logic [127:0]  L_MIN_WIDE = int_min(NI);
  localparam logic [NI-1:0] L_INT_MAX  = L_MAX_WIDE[NI-1:0];
  localparam logic [NI-1:0] L_INT_MIN  = L_MIN_WIDE[NI-1:0];
  localparam logic [NI:0]   L_POS_LIM  = {1'b0, L_INT_MAX};
  localparam logic [NI:0]   L_NEG_LIM  = {1'b0, L_INT_MIN};

  cvt_state_t       r_state;
  logic [NX+NM:0]   r_fp;
  logic [W-1:0]     r_shreg;
  logic [CW-1:0]    r_cnt;
  logic             r_sign;
  logic             r_small;
  logic             r_guard_s;
  logic             r_sticky_s;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [NI-1:0]    r_out_int;
  fp_flags_t        r_flags;

  fp_class_t          w_class;
  logic               w_sign;
  logic signed [NX:0] w_exp;
  int                 w_e_int;
  logic [NM-1:0]      w_mant;
  logic               w_ovf_cls;
  logic               w_small;
  logic [NI-1:0]      w_sat;

  fp_to_int_classify #(
    .NX (NX),
    .NM (NM)
  ) u_classify (
    .i_fp    (r_fp),
    .o_class (w_class),
    .o_sign  (w_sign),
    .o_exp   (w_exp)
  );

  assign w_mant    = r_fp[NM-1:0];
  assign w_e_int   = int'(w_exp);
  assign w_small   = (w_class == FPC_ZERO) || (w_e_int < 0);
  // Only -2^(NI-1) exactly survives an exponent of NI-1.
  assign w_ovf_cls = (w_e_int > NI - 1) ||
                     ((w_e_int == NI - 1) && !(w_sign && (w_mant == '0)));
  assign w_sat     = w_sign ? L_INT_MIN : L_INT_MAX;

  logic [NI:0]   w_mag;
  logic [NM-1:0] w_frac;
  logic          w_guard;
  logic          w_sticky;
  logic          w_inc;
  logic [NI:0]   w_mag_r;
  logic          w_ovf_r;
  logic [NI-1:0] w_neg;
  logic          w_inexact;

  assign w_mag     = r_shreg[W-1:NM];
  assign w_frac    = r_shreg[NM-1:0];
  assign w_guard   = r_small ? r_guard_s  : w_frac[NM-1];
  assign w_sticky  = r_small ? r_sticky_s : (|w_frac[NM-2:0]);
  assign w_inexact = w_guard | w_sticky;

`ifdef FP2INT_ROUND_NEAREST_EN
  assign w_inc = w_guard & (w_sticky | w_mag[0]);
`else
  assign w_inc = 1'b0;
`endif

  assign w_mag_r = w_mag + {{NI{1'b0}}, w_inc};
  assign w_ovf_r = r_sign ? (w_mag_r > L_NEG_LIM) : (w_mag_r > L_POS_LIM);
  assign w_neg   = '0 - w_mag_r[NI-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_fp        <= '0;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_small     <= 1'b0;
      r_guard_s   <= 1'b0;
      r_sticky_s  <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_int   <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_fp       <= i_in_fp;
            r_in_ready <= 1'b0;
            r_state    <= ST_CLASSIFY;
          end
        end

        ST_CLASSIFY: begin
          r_sign     <= w_sign;
          r_small    <= 1'b0;
          r_guard_s  <= 1'b0;
          r_sticky_s <= 1'b0;
          r_shreg    <= '0;
          if (w_class == FPC_NAN) begin
            r_out_int   <= L_INT_MAX;
            r_flags     <= make_flags(1'b1, 1'b0, 1'b0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (w_class == FPC_INF) begin
            r_out_int   <= w_sat;
            r_flags     <= make_flags(1'b1, 1'b0, 1'b0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else if (w_small) begin
            // Below one: the hidden bit is the guard only when e == -1.
            r_small    <= 1'b1;
            r_guard_s  <= (w_class == FPC_NORMAL) && (w_e_int == -1);
            r_sticky_s <= (w_mant != '0) ||
                          ((w_class == FPC_NORMAL) && (w_e_int != -1));
            r_state    <= ST_ROUND;
          end else if (w_ovf_cls) begin
            r_out_int   <= w_sat;
            r_flags     <= make_flags(1'b0, 1'b1, 1'b0);
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_shreg <= {{NI{1'b0}}, 1'b1, w_mant};
            r_cnt   <= w_exp[CW-1:0];
            r_state <= (w_e_int == 0) ? ST_ROUND : ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          r_shreg <= {r_shreg[W-2:0], 1'b0};
          r_cnt   <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == {{(CW-1){1'b0}}, 1'b1}) begin
            r_state <= ST_ROUND;
          end
        end

        ST_ROUND: begin
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
          if (w_ovf_r) begin
            r_out_int <= r_sign ? L_INT_MIN : L_INT_MAX;
            r_flags   <= make_flags(1'b0, 1'b1, 1'b0);
          end else begin
            r_out_int <= r_sign ? w_neg : w_mag_r[NI-1:0];
            r_flags   <= make_flags(1'b0, 1'b0, w_inexact);
          end
        end

        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_int   = r_out_int;
  assign o_out_flags = r_flags;

endmodule
